// File: rtl/sprite_layer_compositor_if.sv
// sprite_layer_compositor_if: pixel/sync/overlay signal bundle between the game top level and the compositor
interface sprite_layer_compositor_if #(
  parameter int N_LAYERS = 11,
  parameter int RGB_W = 12
);
  logic bright_in;
  logic hsync_in;
  logic vsync_in;
  logic frame_start;
  logic [N_LAYERS-1:0] layer_en;
  logic [N_LAYERS*RGB_W-1:0] layer_rgb;
  logic [RGB_W-1:0] bg_rgb;
  logic death_event;
  logic clear_overlay;
  logic [RGB_W-1:0] vga_rgb;
  logic hsync_out;
  logic vsync_out;
  logic overlay_act;
  modport master (
    output bright_in, hsync_in, vsync_in, frame_start, layer_en, layer_rgb, bg_rgb, death_event, clear_overlay,
    input vga_rgb, hsync_out, vsync_out, overlay_act
  );
  modport slave (
    input bright_in, hsync_in, vsync_in, frame_start, layer_en, layer_rgb, bg_rgb, death_event, clear_overlay,
    output vga_rgb, hsync_out, vsync_out, overlay_act
  );
endinterface

// File: rtl/sprite_layer_compositor.sv
// sprite_layer_compositor: 2-stage priority layer mux with blanking, sync delay and death/game-over flash overlay.
// Optional COMPOSITOR_COLOR_KEY_EN: layers whose colour equals COLOR_KEY are treated as transparent.
module sprite_layer_compositor #(
  parameter int N_LAYERS = 11,
  parameter int RGB_W = 12,
  parameter logic [RGB_W-1:0] OVERLAY_RGB = 12'h0F0,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_TOGGLES = 6
`ifdef COMPOSITOR_COLOR_KEY_EN
  , parameter logic [RGB_W-1:0] COLOR_KEY = 12'hF0F
`endif
) (
  input logic clk,
  input logic reset_n,
  sprite_layer_compositor_if.slave bus
);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  typedef enum logic [1:0] {IDLE, FLASH, HOLD} state_t;
  state_t state;
  logic [FW-1:0] frame_cnt;
  logic [TW-1:0] toggle_cnt;
  logic flash_phase;
  logic overlay_lit;
  logic [RGB_W-1:0] pick;
  logic [RGB_W-1:0] sel_rgb;
  logic bright_d1;
  logic hsync_d1;
  logic vsync_d1;
  // Walk from lowest priority upward so the lowest enabled index overwrites last
  always_comb begin
    pick = bus.bg_rgb;
    for (int i = N_LAYERS - 1; i >= 0; i--)
`ifdef COMPOSITOR_COLOR_KEY_EN
      if (bus.layer_en[i] && bus.layer_rgb[i*RGB_W +: RGB_W] != COLOR_KEY) pick = bus.layer_rgb[i*RGB_W +: RGB_W];
`else
      if (bus.layer_en[i]) pick = bus.layer_rgb[i*RGB_W +: RGB_W];
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sel_rgb <= '0;
      bright_d1 <= 1'b0;
      hsync_d1 <= 1'b1;
      vsync_d1 <= 1'b1;
      bus.vga_rgb <= '0;
      bus.hsync_out <= 1'b1;
      bus.vsync_out <= 1'b1;
    end else begin
      sel_rgb <= pick;
      bright_d1 <= bus.bright_in;
      hsync_d1 <= bus.hsync_in;
      vsync_d1 <= bus.vsync_in;
      bus.vga_rgb <= !bright_d1 ? '0 : overlay_lit ? OVERLAY_RGB : sel_rgb;
      bus.hsync_out <= hsync_d1;
      bus.vsync_out <= vsync_d1;
    end
  // overlay_lit/overlay_act are set alongside each state change so they track state without extra lag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      frame_cnt <= '0;
      toggle_cnt <= '0;
      flash_phase <= 1'b0;
      overlay_lit <= 1'b0;
      bus.overlay_act <= 1'b0;
    end else if (bus.clear_overlay) begin
      state <= IDLE;
      overlay_lit <= 1'b0;
      bus.overlay_act <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.death_event) begin
            state <= FLASH;
            flash_phase <= 1'b1;
            frame_cnt <= '0;
            toggle_cnt <= '0;
            overlay_lit <= 1'b1;
            bus.overlay_act <= 1'b1;
          end
        FLASH:
          if (bus.frame_start) begin
            if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
              frame_cnt <= '0;
              flash_phase <= ~flash_phase;
              toggle_cnt <= toggle_cnt + 1'b1;
              if (toggle_cnt == TW'(FLASH_TOGGLES - 1)) begin
                state <= HOLD;
                overlay_lit <= 1'b1;
              end else
                overlay_lit <= ~flash_phase;
            end else
              frame_cnt <= frame_cnt + 1'b1;
          end
        HOLD: ;
        default: begin
          state <= IDLE;
          overlay_lit <= 1'b0;
          bus.overlay_act <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_sprite_layer_compositor.sv
// tb_sprite_layer_compositor: directed vectors for priority, blanking, sync delay, flash overlay and async reset
module tb_sprite_layer_compositor;
  logic clk;
  logic reset_n;
  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] lit_seq = 8'b1111_1001;
  sprite_layer_compositor_if #(.N_LAYERS(11), .RGB_W(12)) bus ();
  sprite_layer_compositor #(
    .N_LAYERS(11),
    .RGB_W(12),
    .OVERLAY_RGB(12'h0F0),
    .FLASH_FRAMES(2),
    .FLASH_TOGGLES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_layer(input int i, input logic [11:0] c, input logic e);
    bus.layer_rgb[i*12 +: 12] = c;
    bus.layer_en[i] = e;
  endtask
  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    tick(2);
  endtask
  initial begin
    reset_n = 1'b0;
    bus.bright_in = 1'b1;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.frame_start = 1'b0;
    bus.layer_en = '0;
    bus.layer_rgb = '0;
    bus.bg_rgb = 12'h777;
    bus.death_event = 1'b0;
    bus.clear_overlay = 1'b0;
    tick(3);
    check("rst_rgb", 32'(bus.vga_rgb), 32'h0);
    check("rst_hs", 32'(bus.hsync_out), 32'h1);
    check("rst_vs", 32'(bus.vsync_out), 32'h1);
    check("rst_act", 32'(bus.overlay_act), 32'h0);
    reset_n = 1'b1;
    set_layer(3, 12'h123, 1'b1);
    set_layer(7, 12'h456, 1'b1);
    tick(2);
    check("prio_3_7", 32'(bus.vga_rgb), 32'h123);
    set_layer(3, 12'h123, 1'b0);
    tick(2);
    check("prio_7", 32'(bus.vga_rgb), 32'h456);
    bus.layer_en = '0;
    tick(2);
    check("prio_bg", 32'(bus.vga_rgb), 32'h777);
    set_layer(10, 12'hA0A, 1'b1);
    tick(2);
    check("prio_10", 32'(bus.vga_rgb), 32'hA0A);
    set_layer(0, 12'h001, 1'b1);
    bus.layer_en = '1;
    tick(2);
    check("prio_all", 32'(bus.vga_rgb), 32'h001);
    bus.bright_in = 1'b0;
    tick(2);
    check("blank", 32'(bus.vga_rgb), 32'h0);
    bus.bright_in = 1'b1;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    tick(1);
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    check("hs_t1", 32'(bus.hsync_out), 32'h1);
    tick(1);
    check("hs_t2", 32'(bus.hsync_out), 32'h0);
    check("vs_t2", 32'(bus.vsync_out), 32'h0);
    tick(1);
    check("hs_t3", 32'(bus.hsync_out), 32'h1);
    bus.layer_en = '0;
    set_layer(0, 12'hF0F, 1'b1);
    set_layer(1, 12'hABC, 1'b1);
    tick(2);
`ifdef COMPOSITOR_COLOR_KEY_EN
    check("ckey", 32'(bus.vga_rgb), 32'hABC);
`else
    check("ckey", 32'(bus.vga_rgb), 32'hF0F);
`endif
    bus.layer_en = '0;
    set_layer(0, 12'h123, 1'b1);
    bus.death_event = 1'b1;
    bus.clear_overlay = 1'b1;
    tick(1);
    bus.death_event = 1'b0;
    bus.clear_overlay = 1'b0;
    tick(2);
    check("coll_act", 32'(bus.overlay_act), 32'h0);
    check("coll_rgb", 32'(bus.vga_rgb), 32'h123);
    bus.death_event = 1'b1;
    tick(1);
    bus.death_event = 1'b0;
    tick(2);
    check("flash_start_rgb", 32'(bus.vga_rgb), 32'h0F0);
    check("flash_start_act", 32'(bus.overlay_act), 32'h1);
    for (int k = 0; k < 8; k++) begin
      frame_pulse();
      check($sformatf("flash_rgb_f%0d", k + 1), 32'(bus.vga_rgb), lit_seq[k] ? 32'h0F0 : 32'h123);
      check($sformatf("flash_act_f%0d", k + 1), 32'(bus.overlay_act), 32'h1);
      if (k == 1) begin
        bus.death_event = 1'b1;
        tick(1);
        bus.death_event = 1'b0;
        tick(2);
        check("death_ignored", 32'(bus.vga_rgb), 32'h123);
      end
    end
    bus.clear_overlay = 1'b1;
    tick(1);
    bus.clear_overlay = 1'b0;
    tick(2);
    check("clear_act", 32'(bus.overlay_act), 32'h0);
    check("clear_rgb", 32'(bus.vga_rgb), 32'h123);
    bus.death_event = 1'b1;
    tick(1);
    bus.death_event = 1'b0;
    bus.hsync_in = 1'b0;
    tick(2);
    check("pre_rst_rgb", 32'(bus.vga_rgb), 32'h0F0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_rgb", 32'(bus.vga_rgb), 32'h0);
    check("arst_act", 32'(bus.overlay_act), 32'h0);
    check("arst_hs", 32'(bus.hsync_out), 32'h1);
    check("arst_vs", 32'(bus.vsync_out), 32'h1);
    #2;
    reset_n = 1'b1;
    bus.hsync_in = 1'b1;
    tick(2);
    check("resume_rgb", 32'(bus.vga_rgb), 32'h123);
    check("resume_act", 32'(bus.overlay_act), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
